l2_port_arbiter: RTL and testbench

// - Sole owner of the L1->L2 refill/writeback port. Arbitrates ICache miss, DCache miss and DCache write-buffer drain.
// - Sequences one line transaction at a time: address phase, then a BEATS-long read or write data burst.
// - Sits between the L1 caches/write buffer and the L2 cache controller.

---
 rtl/l2_port_arbiter_pkg.sv | 44 ++++
 rtl/l2_port_arbiter_rr.sv | 54 +++++
 rtl/l2_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// ==================================================================
// l2_port_arbiter_pkg : owner/state types and cache-line geometry helpers
// Rev 1.0
// ==================================================================
`default_nettype none

package l2_port_arbiter_pkg;

    localparam int CACHE_BLOCK_SIZE = 64;

    typedef enum logic [1:0] {
        OWN_DC = 2'd0,
        OWN_IC = 2'd1,
        OWN_WB = 2'd2
    } l2_owner_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        RBURST = 3'd2,
        WBURST = 3'd3,
        DONE   = 3'd4
    } l2_arb_state_e;

    function automatic int beats_f(input int blk_bytes, input int data_w);
        return (blk_bytes * 8) / data_w;
    endfunction

    function automatic int ofs_f(input int blk_bytes);
        return $clog2(blk_bytes);
    endfunction

    // Round-robin successor in the fixed ring DC -> IC -> WB -> DC.
    function automatic l2_owner_e owner_next(input l2_owner_e o);
        case (o)
            OWN_DC:  return OWN_IC;
            OWN_IC:  return OWN_WB;
            default: return OWN_DC;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_port_arbiter_rr.sv
// ==================================================================
// rr_arbiter3 : 3-way round-robin picker with registered start pointer
// Rev 1.0
// ==================================================================
`default_nettype none

module rr_arbiter3
    import l2_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       upd_i,
    input  l2_owner_e  win_i,
    output l2_owner_e  rr_win_o,
    output logic       rr_valid_o
);

    l2_owner_e ptr_q;
    l2_owner_e ptr_d;
    l2_owner_e w_cand;

    always_comb begin
        rr_win_o   = ptr_q;
        rr_valid_o = 1'b0;
        w_cand     = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!rr_valid_o && req_i[w_cand]) begin
                rr_win_o   = w_cand;
                rr_valid_o = 1'b1;
            end
            w_cand = owner_next(w_cand);
        end
    end

    // The pointer follows the actual winner, including priority overrides.
    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = owner_next(win_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= OWN_DC;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l2_port_arbiter.sv
// ==================================================================
// l2_port_arbiter : owns the L1<->L2 line port; one line transaction at a time
// Rev 1.0
// ==================================================================
`default_nettype none

module l2_port_arbiter #(
    parameter int CACHE_BLOCK_SIZE = l2_port_arbiter_pkg::CACHE_BLOCK_SIZE,
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_gnt_o,
    output logic              ic_rvalid_o,
    output logic              ic_done_o,
    input  logic              dc_req_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    output logic              dc_gnt_o,
    output logic              dc_rvalid_o,
    output logic              dc_done_o,
    input  logic              wb_req_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic              wb_full_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    output logic              wb_pop_o,
    output logic              wb_gnt_o,
    output logic              wb_done_o,
    output logic [DATA_W-1:0] l1_rdata_o,
    output logic              l2_req_o,
    output logic              l2_we_o,
    output logic [ADDR_W-1:0] l2_addr_o,
    input  logic              l2_ack_i,
    input  logic [DATA_W-1:0] l2_rdata_i,
    input  logic              l2_rvalid_i,
    output logic [DATA_W-1:0] l2_wdata_o,
    output logic              l2_wvalid_o,
    input  logic              l2_wready_i
);

    import l2_port_arbiter_pkg::*;

    localparam int                BEATS     = beats_f(CACHE_BLOCK_SIZE, DATA_W);
    localparam int                OFS       = ofs_f(CACHE_BLOCK_SIZE);
    localparam int                BW        = $clog2(BEATS);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFS;

    l2_arb_state_e     state_q, state_d;
    l2_owner_e         owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     beat_q, beat_d;

    logic [2:0]        w_req;
    logic              w_force_wb;
    l2_owner_e         w_rr_win;
    logic              w_rr_valid;
    l2_owner_e         w_win;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_grant;
    logic              w_owner_req;

    assign w_req = {wb_req_i, ic_req_i, dc_req_i};

    // A pending writeback to the same line as a DCache miss must reach L2 first.
    assign w_force_wb = wb_req_i &
                        (wb_full_i | (dc_req_i & (((wb_addr_i ^ dc_addr_i) & LINE_MASK) == '0)));
    assign w_win      = w_force_wb ? OWN_WB : w_rr_win;
    assign w_grant    = (state_q == IDLE) & w_rr_valid & ~rst;

    always_comb begin
        case (w_win)
            OWN_DC:  w_win_addr = dc_addr_i;
            OWN_IC:  w_win_addr = ic_addr_i;
            default: w_win_addr = wb_addr_i;
        endcase
    end

    rr_arbiter3 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_i      (w_req),
        .upd_i      (w_grant),
        .win_i      (w_win),
        .rr_win_o   (w_rr_win),
        .rr_valid_o (w_rr_valid)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        ic_gnt_o    = 1'b0;
        ic_rvalid_o = 1'b0;
        ic_done_o   = 1'b0;
        dc_gnt_o    = 1'b0;
        dc_rvalid_o = 1'b0;
        dc_done_o   = 1'b0;
        wb_gnt_o    = 1'b0;
        wb_done_o   = 1'b0;
        wb_pop_o    = 1'b0;
        l2_req_o    = 1'b0;
        l2_we_o     = 1'b0;
        l2_wvalid_o = 1'b0;
        l2_addr_o   = addr_q;
        l1_rdata_o  = l2_rdata_i;
        l2_wdata_o  = wb_wdata_i;
        case (state_q)
            IDLE: begin
                if (w_grant) begin
                    case (w_win)
                        OWN_DC:  dc_gnt_o = 1'b1;
                        OWN_IC:  ic_gnt_o = 1'b1;
                        default: wb_gnt_o = 1'b1;
                    endcase
                    owner_d = w_win;
                    addr_d  = w_win_addr & LINE_MASK;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                l2_req_o = 1'b1;
                l2_we_o  = (owner_q == OWN_WB);
                if (l2_ack_i) begin
                    state_d = (owner_q == OWN_WB) ? WBURST : RBURST;
                    beat_d  = '0;
                end
            end
            RBURST: begin
                if (l2_rvalid_i) begin
                    if (owner_q == OWN_IC) begin
                        ic_rvalid_o = 1'b1;
                    end else begin
                        dc_rvalid_o = 1'b1;
                    end
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WBURST: begin
                l2_wvalid_o = 1'b1;
                wb_pop_o    = l2_wready_i;
                if (l2_wready_i) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                case (owner_q)
                    OWN_DC:  dc_done_o = 1'b1;
                    OWN_IC:  ic_done_o = 1'b1;
                    default: wb_done_o = 1'b1;
                endcase
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_DC;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        case (owner_q)
            OWN_DC:  w_owner_req = dc_req_i;
            OWN_IC:  w_owner_req = ic_req_i;
            default: w_owner_req = wb_req_i;
        endcase
    end

    a_req_held_until_done: assert property (
        @(posedge clk) disable iff (rst) (state_q != IDLE) |-> w_owner_req
    );

endmodule

`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
// ==================================================================
// tb_l2_port_arbiter : directed scenario bench for l2_port_arbiter
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_l2_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ic_req_i, dc_req_i, wb_req_i, wb_full_i;
    logic [ADDR_W-1:0] ic_addr_i, dc_addr_i, wb_addr_i;
    logic [DATA_W-1:0] wb_wdata_i, l2_rdata_i;
    logic              l2_ack_i, l2_rvalid_i, l2_wready_i;
    logic              ic_gnt_o, ic_rvalid_o, ic_done_o;
    logic              dc_gnt_o, dc_rvalid_o, dc_done_o;
    logic              wb_pop_o, wb_gnt_o, wb_done_o;
    logic [DATA_W-1:0] l1_rdata_o, l2_wdata_o;
    logic              l2_req_o, l2_we_o, l2_wvalid_o;
    logic [ADDR_W-1:0] l2_addr_o;

    int n_chk  = 0;
    int n_pass = 0;

    wire [11:0] outs = {ic_gnt_o, ic_rvalid_o, ic_done_o, dc_gnt_o, dc_rvalid_o, dc_done_o,
                        wb_gnt_o, wb_done_o, wb_pop_o, l2_req_o, l2_we_o, l2_wvalid_o};
    wire [2:0]  gnts = {wb_gnt_o, ic_gnt_o, dc_gnt_o};
    wire [2:0]  dones = {wb_done_o, ic_done_o, dc_done_o};

    always #5 clk = ~clk;

    l2_port_arbiter #(
        .CACHE_BLOCK_SIZE (64),
        .DATA_W           (DATA_W),
        .ADDR_W           (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_req_i    (ic_req_i),
        .ic_addr_i   (ic_addr_i),
        .ic_gnt_o    (ic_gnt_o),
        .ic_rvalid_o (ic_rvalid_o),
        .ic_done_o   (ic_done_o),
        .dc_req_i    (dc_req_i),
        .dc_addr_i   (dc_addr_i),
        .dc_gnt_o    (dc_gnt_o),
        .dc_rvalid_o (dc_rvalid_o),
        .dc_done_o   (dc_done_o),
        .wb_req_i    (wb_req_i),
        .wb_addr_i   (wb_addr_i),
        .wb_full_i   (wb_full_i),
        .wb_wdata_i  (wb_wdata_i),
        .wb_pop_o    (wb_pop_o),
        .wb_gnt_o    (wb_gnt_o),
        .wb_done_o   (wb_done_o),
        .l1_rdata_o  (l1_rdata_o),
        .l2_req_o    (l2_req_o),
        .l2_we_o     (l2_we_o),
        .l2_addr_o   (l2_addr_o),
        .l2_ack_i    (l2_ack_i),
        .l2_rdata_i  (l2_rdata_i),
        .l2_rvalid_i (l2_rvalid_i),
        .l2_wdata_o  (l2_wdata_o),
        .l2_wvalid_o (l2_wvalid_o),
        .l2_wready_i (l2_wready_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ic_req_i = 1'b0; dc_req_i = 1'b0; wb_req_i = 1'b0; wb_full_i = 1'b0;
        l2_ack_i = 1'b0; l2_rvalid_i = 1'b0; l2_wready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives a granted transaction from its ADDR cycle through DONE; caller is left in DONE.
    task automatic run_txn(input bit wr, output logic [ADDR_W-1:0] a, output logic we,
                           output int beats, output logic [2:0] done);
        tick();
        a = l2_addr_o;
        we = l2_we_o;
        l2_ack_i = 1'b1;
        settle();
        tick();
        l2_ack_i = 1'b0;
        beats = 0;
        for (int i = 0; i < 16; i++) begin
            if (wr) begin
                l2_wready_i = 1'b1;
                wb_wdata_i  = 32'hC000_0000 + i;
            end else begin
                l2_rvalid_i = 1'b1;
                l2_rdata_i  = 32'hB000_0000 + i;
            end
            settle();
            if (wr ? wb_pop_o : (ic_rvalid_o | dc_rvalid_o)) beats++;
            tick();
        end
        l2_rvalid_i = 1'b0;
        l2_wready_i = 1'b0;
        settle();
        done = dones;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_chk++; if (outs !== 12'h000) $display("FAIL reset_outs: got %h want %h", outs, 12'h000); else n_pass++;
        n_chk++; if (l2_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want %h", l2_addr_o, 32'h0); else n_pass++;
    endtask

    task automatic test_ic_read();
        int  cnt;
        bit  data_ok;
        do_reset();
        ic_addr_i = 32'h0000_1234;
        ic_req_i  = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b010) $display("FAIL ic_gnt_c0: got %b want %b", gnts, 3'b010); else n_pass++;
        n_chk++; if (l2_req_o !== 1'b0) $display("FAIL ic_l2req_c0: got %b want %b", l2_req_o, 1'b0); else n_pass++;
        tick();
        n_chk++; if (l2_req_o !== 1'b1) $display("FAIL ic_l2req_c1: got %b want %b", l2_req_o, 1'b1); else n_pass++;
        n_chk++; if (l2_addr_o !== 32'h0000_1200) $display("FAIL ic_addr: got %h want %h", l2_addr_o, 32'h0000_1200); else n_pass++;
        n_chk++; if (l2_we_o !== 1'b0) $display("FAIL ic_we: got %b want %b", l2_we_o, 1'b0); else n_pass++;
        tick();
        n_chk++; if ({l2_req_o, l2_addr_o} !== {1'b1, 32'h0000_1200}) $display("FAIL ic_addr_hold: got %b/%h want 1/00001200", l2_req_o, l2_addr_o); else n_pass++;
        tick();
        l2_ack_i = 1'b1;
        settle();
        tick();
        l2_ack_i = 1'b0;
        cnt = 0;
        data_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            l2_rvalid_i = 1'b1;
            l2_rdata_i  = 32'hA5A5_0000 + i;
            settle();
            if (ic_rvalid_o && !dc_rvalid_o) cnt++;
            if (l1_rdata_o !== 32'hA5A5_0000 + i || ic_done_o) data_ok = 1'b0;
            tick();
        end
        l2_rvalid_i = 1'b1;
        settle();
        n_chk++; if (cnt !== 16) $display("FAIL ic_beats: got %0d want %0d", cnt, 16); else n_pass++;
        n_chk++; if (data_ok !== 1'b1) $display("FAIL ic_rdata: got %b want %b", data_ok, 1'b1); else n_pass++;
        n_chk++; if (dones !== 3'b010) $display("FAIL ic_done: got %b want %b", dones, 3'b010); else n_pass++;
        n_chk++; if (ic_rvalid_o !== 1'b0) $display("FAIL ic_stray_beat: got %b want %b", ic_rvalid_o, 1'b0); else n_pass++;
        tick();
        l2_rvalid_i = 1'b0;
        ic_req_i = 1'b0;
        settle();
        n_chk++; if (outs !== 12'h000) $display("FAIL ic_after_done: got %h want %h", outs, 12'h000); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] a;
        logic              we;
        int                beats;
        logic [2:0]        done;
        do_reset();
        dc_addr_i = 32'h1000_0040; ic_addr_i = 32'h2000_0080; wb_addr_i = 32'h3000_00C4;
        dc_req_i = 1'b1; ic_req_i = 1'b1; wb_req_i = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b001) $display("FAIL rr_first_dc: got %b want %b", gnts, 3'b001); else n_pass++;
        run_txn(1'b0, a, we, beats, done);
        n_chk++; if ({a, we, done} !== {32'h1000_0040, 1'b0, 3'b001}) $display("FAIL rr_dc_txn: got %h/%b/%b want 10000040/0/001", a, we, done); else n_pass++;
        tick();
        dc_req_i = 1'b0;
        settle();
        n_chk++; if (gnts !== 3'b010) $display("FAIL rr_second_ic: got %b want %b", gnts, 3'b010); else n_pass++;
        run_txn(1'b0, a, we, beats, done);
        n_chk++; if ({a, we, done} !== {32'h2000_0080, 1'b0, 3'b010}) $display("FAIL rr_ic_txn: got %h/%b/%b want 20000080/0/010", a, we, done); else n_pass++;
        tick();
        ic_req_i = 1'b0;
        settle();
        n_chk++; if (gnts !== 3'b100) $display("FAIL rr_third_wb: got %b want %b", gnts, 3'b100); else n_pass++;
        run_txn(1'b1, a, we, beats, done);
        n_chk++; if ({a, we, done, beats} !== {32'h3000_00C0, 1'b1, 3'b100, 32'd16}) $display("FAIL rr_wb_txn: got %h/%b/%b/%0d want 300000c0/1/100/16", a, we, done, beats); else n_pass++;
        tick();
        wb_req_i = 1'b0;
        dc_req_i = 1'b1; ic_req_i = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b001) $display("FAIL rr_wrap_dc: got %b want %b", gnts, 3'b001); else n_pass++;
        run_txn(1'b0, a, we, beats, done);
        tick();
        dc_req_i = 1'b0; ic_req_i = 1'b0;
    endtask

    task automatic test_raw_priority();
        logic [ADDR_W-1:0] a;
        logic              we;
        int                beats;
        logic [2:0]        done;
        do_reset();
        dc_addr_i = 32'h0000_8040; wb_addr_i = 32'h0000_8078;
        dc_req_i = 1'b1; wb_req_i = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b100) $display("FAIL raw_wb_first: got %b want %b", gnts, 3'b100); else n_pass++;
        run_txn(1'b1, a, we, beats, done);
        n_chk++; if ({a, we, done} !== {32'h0000_8040, 1'b1, 3'b100}) $display("FAIL raw_wb_txn: got %h/%b/%b want 00008040/1/100", a, we, done); else n_pass++;
        tick();
        wb_req_i = 1'b0;
        settle();
        n_chk++; if (gnts !== 3'b001) $display("FAIL raw_dc_next: got %b want %b", gnts, 3'b001); else n_pass++;
        run_txn(1'b0, a, we, beats, done);
        n_chk++; if ({a, we, done, beats} !== {32'h0000_8040, 1'b0, 3'b001, 32'd16}) $display("FAIL raw_dc_txn: got %h/%b/%b/%0d want 00008040/0/001/16", a, we, done, beats); else n_pass++;
        tick();
        dc_req_i = 1'b0;
    endtask

    task automatic test_wb_stall();
        int k, cyc;
        bit s3, s9, wr, wv_ok, data_ok, pop_ok;
        do_reset();
        wb_addr_i = 32'h4000_0100;
        wb_req_i  = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b100) $display("FAIL wbs_gnt: got %b want %b", gnts, 3'b100); else n_pass++;
        tick();
        n_chk++; if ({l2_req_o, l2_we_o} !== 2'b11) $display("FAIL wbs_addr_phase: got %b want %b", {l2_req_o, l2_we_o}, 2'b11); else n_pass++;
        l2_ack_i = 1'b1;
        settle();
        tick();
        l2_ack_i = 1'b0;
        k = 0; cyc = 0; s3 = 1'b0; s9 = 1'b0;
        wv_ok = 1'b1; data_ok = 1'b1; pop_ok = 1'b1;
        while (k < 16 && cyc < 40) begin
            wr = 1'b1;
            if (k == 3 && !s3) begin wr = 1'b0; s3 = 1'b1; end
            if (k == 9 && !s9) begin wr = 1'b0; s9 = 1'b1; end
            wb_wdata_i  = 32'hD000_0000 + k;
            l2_wready_i = wr;
            settle();
            if (l2_wvalid_o !== 1'b1) wv_ok = 1'b0;
            if (l2_wdata_o !== 32'hD000_0000 + k) data_ok = 1'b0;
            if (wb_pop_o !== wr) pop_ok = 1'b0;
            if (wb_pop_o === 1'b1) k++;
            cyc++;
            tick();
        end
        l2_wready_i = 1'b0;
        settle();
        n_chk++; if (k !== 16) $display("FAIL wbs_pops: got %0d want %0d", k, 16); else n_pass++;
        n_chk++; if (cyc !== 18) $display("FAIL wbs_cycles: got %0d want %0d", cyc, 18); else n_pass++;
        n_chk++; if (wv_ok !== 1'b1) $display("FAIL wbs_wvalid_held: got %b want %b", wv_ok, 1'b1); else n_pass++;
        n_chk++; if (data_ok !== 1'b1) $display("FAIL wbs_data_order: got %b want %b", data_ok, 1'b1); else n_pass++;
        n_chk++; if (pop_ok !== 1'b1) $display("FAIL wbs_pop_vs_ready: got %b want %b", pop_ok, 1'b1); else n_pass++;
        n_chk++; if ({dones, l2_wvalid_o} !== 4'b1000) $display("FAIL wbs_done: got %b want %b", {dones, l2_wvalid_o}, 4'b1000); else n_pass++;
        tick();
        wb_req_i = 1'b0;
    endtask

    task automatic test_wb_full();
        logic [ADDR_W-1:0] a;
        logic              we;
        int                beats;
        logic [2:0]        done;
        do_reset();
        dc_addr_i = 32'h5000_0000;
        dc_req_i  = 1'b1;
        settle();
        run_txn(1'b0, a, we, beats, done);
        tick();
        dc_req_i  = 1'b0;
        ic_addr_i = 32'h6000_0000; ic_req_i = 1'b1;
        wb_addr_i = 32'h7000_0000; wb_req_i = 1'b1; wb_full_i = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b100) $display("FAIL full_wb_wins: got %b want %b", gnts, 3'b100); else n_pass++;
        run_txn(1'b1, a, we, beats, done);
        n_chk++; if ({a, we, done} !== {32'h7000_0000, 1'b1, 3'b100}) $display("FAIL full_wb_txn: got %h/%b/%b want 70000000/1/100", a, we, done); else n_pass++;
        tick();
        wb_req_i = 1'b0; wb_full_i = 1'b0;
        settle();
        n_chk++; if (gnts !== 3'b010) $display("FAIL full_ic_next: got %b want %b", gnts, 3'b010); else n_pass++;
        run_txn(1'b0, a, we, beats, done);
        tick();
        ic_req_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a;
        logic              we;
        int                beats;
        logic [2:0]        done;
        do_reset();
        dc_addr_i = 32'h0000_2040;
        dc_req_i  = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b001) $display("FAIL rmid_gnt: got %b want %b", gnts, 3'b001); else n_pass++;
        tick();
        l2_ack_i = 1'b1;
        settle();
        tick();
        l2_ack_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            l2_rvalid_i = 1'b1;
            settle();
            tick();
        end
        rst = 1'b1;
        dc_req_i = 1'b0;
        settle();
        tick();
        rst = 1'b0;
        l2_rvalid_i = 1'b1;
        settle();
        n_chk++; if (outs !== 12'h000) $display("FAIL rmid_outs: got %h want %h", outs, 12'h000); else n_pass++;
        n_chk++; if (l2_addr_o !== 32'h0) $display("FAIL rmid_addr: got %h want %h", l2_addr_o, 32'h0); else n_pass++;
        tick();
        l2_rvalid_i = 1'b0;
        settle();
        n_chk++; if (outs !== 12'h000) $display("FAIL rmid_no_done: got %h want %h", outs, 12'h000); else n_pass++;
        dc_addr_i = 32'h0000_3000;
        dc_req_i  = 1'b1;
        settle();
        n_chk++; if (gnts !== 3'b001) $display("FAIL rmid_regnt: got %b want %b", gnts, 3'b001); else n_pass++;
        run_txn(1'b0, a, we, beats, done);
        n_chk++; if ({a, beats, done} !== {32'h0000_3000, 32'd16, 3'b001}) $display("FAIL rmid_fresh_txn: got %h/%0d/%b want 00003000/16/001", a, beats, done); else n_pass++;
        tick();
        dc_req_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ic_req_i = 1'b0; dc_req_i = 1'b0; wb_req_i = 1'b0; wb_full_i = 1'b0;
        ic_addr_i = '0; dc_addr_i = '0; wb_addr_i = '0;
        wb_wdata_i = '0; l2_rdata_i = '0;
        l2_ack_i = 1'b0; l2_rvalid_i = 1'b0; l2_wready_i = 1'b0;
        test_reset();
        test_ic_read();
        test_round_robin();
        test_raw_priority();
        test_wb_stall();
        test_wb_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
